// File: rtl/gecko_execute_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring divider.
// Optional macro GECKO_MULDIV_FASTPATH_EN completes trivial operands at accept.
module gecko_execute_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [XLEN-1:0] cmd_rs1,
    input  logic [XLEN-1:0] cmd_rs2,
    input  logic [4:0]      cmd_reg_addr,
    input  logic            cmd_speculative,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result_value,
    output logic [4:0]      result_addr,
    output logic            busy
);
    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        addr_q, addr_d;
    logic              spec_q, spec_d, sa_q, sa_d, sb_q, sb_d, bzero_q, bzero_d;
    logic              result_valid_q, result_valid_d;
    logic [XLEN-1:0]   result_value_q, result_value_d;
    logic [4:0]        result_addr_q, result_addr_d;

    logic              a_signed, b_signed, sa_cmd, sb_cmd;
    logic [XLEN-1:0]   amag, bmag, hi_it, lo_it, fin;
    logic [XLEN:0]     sum, rsh, diff;
    logic [2*XLEN-1:0] prod, prod_n;

    // Operand magnitudes and effective signs, decided at accept.
    always_comb begin
        a_signed = (cmd_op == 3'd0) || (cmd_op == 3'd1) || (cmd_op == 3'd2) ||
                   (cmd_op == 3'd4) || (cmd_op == 3'd6);
        b_signed = (cmd_op == 3'd0) || (cmd_op == 3'd1) ||
                   (cmd_op == 3'd4) || (cmd_op == 3'd6);
        sa_cmd   = a_signed & cmd_rs1[XLEN-1];
        sb_cmd   = b_signed & cmd_rs2[XLEN-1];
        amag     = sa_cmd ? -cmd_rs1 : cmd_rs1;
        bmag     = sb_cmd ? -cmd_rs2 : cmd_rs2;
    end

    // hi/lo hold accumulator/multiplier for MUL and remainder/quotient for DIV.
    always_comb begin
        hi_it = hi_q;
        lo_it = lo_q;
        sum   = '0;
        rsh   = '0;
        diff  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!op_q[2]) begin
                sum   = {1'b0, hi_it} + (lo_it[0] ? {1'b0, opb_q} : '0);
                lo_it = {sum[0], lo_it[XLEN-1:1]};
                hi_it = sum[XLEN:1];
            end else begin
                rsh   = {hi_it, lo_it[XLEN-1]};
                lo_it = {lo_it[XLEN-2:0], 1'b0};
                diff  = rsh - {1'b0, opb_q};
                if (!diff[XLEN]) begin
                    hi_it    = diff[XLEN-1:0];
                    lo_it[0] = 1'b1;
                end else begin
                    hi_it = rsh[XLEN-1:0];
                end
            end
        end
    end

    always_comb begin
        prod   = {hi_it, lo_it};
        prod_n = -prod;
        fin    = '0;
        case (op_q)
            3'd0:                fin = (sa_q ^ sb_q) ? prod_n[XLEN-1:0] : prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin = (sa_q ^ sb_q) ? prod_n[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
            // Divide by zero must yield all-ones even when the dividend is negative.
            3'd4, 3'd5:          fin = bzero_q ? '1 : ((sa_q ^ sb_q) ? -lo_it : lo_it);
            default:             fin = sa_q ? -hi_it : hi_it;
        endcase
    end

`ifdef GECKO_MULDIV_FASTPATH_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_val;
    logic            ovf_cmd;

    always_comb begin
        ovf_cmd  = ((cmd_op == 3'd4) || (cmd_op == 3'd6)) &&
                   (cmd_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (cmd_rs2 == '1);
        fast_hit = 1'b0;
        fast_val = '0;
        if (!cmd_op[2]) begin
            fast_hit = (cmd_rs1 == '0) || (cmd_rs2 == '0);
        end else if (cmd_rs2 == '0) begin
            fast_hit = 1'b1;
            fast_val = cmd_op[1] ? cmd_rs1 : '1;
        end else if (ovf_cmd) begin
            fast_hit = 1'b1;
            fast_val = cmd_op[1] ? '0 : cmd_rs1;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        opb_d          = opb_q;
        op_d           = op_q;
        addr_d         = addr_q;
        spec_d         = spec_q;
        sa_d           = sa_q;
        sb_d           = sb_q;
        bzero_d        = bzero_q;
        result_valid_d = result_valid_q;
        result_value_d = result_value_q;
        result_addr_d  = result_addr_q;
        cmd_ready      = rst && (state_q == S_IDLE) && !flush;
        busy           = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    hi_d    = '0;
                    lo_d    = amag;
                    opb_d   = bmag;
                    op_d    = cmd_op;
                    addr_d  = cmd_reg_addr;
                    spec_d  = cmd_speculative;
                    sa_d    = sa_cmd;
                    sb_d    = sb_cmd;
                    bzero_d = (cmd_rs2 == '0);
                    count_d = CW'(ITER - 1);
                    state_d = S_BUSY;
`ifdef GECKO_MULDIV_FASTPATH_EN
                    if (fast_hit) begin
                        count_d        = '0;
                        state_d        = S_DONE;
                        result_valid_d = 1'b1;
                        result_value_d = fast_val;
                        result_addr_d  = cmd_reg_addr;
                    end
`endif
                end
            end
            S_BUSY: begin
                hi_d    = hi_it;
                lo_d    = lo_it;
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    count_d        = '0;
                    state_d        = S_DONE;
                    result_valid_d = 1'b1;
                    result_value_d = fin;
                    result_addr_d  = addr_q;
                end
                if (spec_q && flush) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                end
            end
            S_DONE: begin
                if (result_ready || (spec_q && flush)) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = S_IDLE;
                result_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            opb_q          <= '0;
            op_q           <= '0;
            addr_q         <= '0;
            spec_q         <= 1'b0;
            sa_q           <= 1'b0;
            sb_q           <= 1'b0;
            bzero_q        <= 1'b0;
            result_valid_q <= 1'b0;
            result_value_q <= '0;
            result_addr_q  <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            opb_q          <= opb_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            spec_q         <= spec_d;
            sa_q           <= sa_d;
            sb_q           <= sb_d;
            bzero_q        <= bzero_d;
            result_valid_q <= result_valid_d;
            result_value_q <= result_value_d;
            result_addr_q  <= result_addr_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result_value = result_value_q;
    assign result_addr  = result_addr_q;
endmodule

// File: tb/tb_gecko_execute_muldiv.sv
// Bench for gecko_execute_muldiv: BPC=1 and BPC=4 instances driven in lockstep,
// checked against an arithmetic reference model.
module tb_gecko_execute_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_rs1 = '0, cmd_rs2 = '0;
    logic [4:0]  cmd_reg_addr = '0;
    logic        cmd_speculative = 1'b0;
    logic        flush = 1'b0;
    logic        result_ready = 1'b0;

    logic        crdy0, rv0, busy0, crdy4, rv4, busy4;
    logic [31:0] val0, val4;
    logic [4:0]  ad0, ad4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gecko_execute_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(crdy0), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_reg_addr(cmd_reg_addr),
        .cmd_speculative(cmd_speculative), .flush(flush), .result_valid(rv0),
        .result_ready(result_ready), .result_value(val0), .result_addr(ad0), .busy(busy0));

    gecko_execute_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(crdy4), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_reg_addr(cmd_reg_addr),
        .cmd_speculative(cmd_speculative), .flush(flush), .result_valid(rv4),
        .result_ready(result_ready), .result_value(val4), .result_addr(ad4), .busy(busy4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, ubs, p;
        logic [63:0] up;
        logic ovf;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ubs = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = sa * sb;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * ubs; r = p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: if (b == 0) r = '1; else if (ovf) r = a; else begin p = sa / sb; r = p[31:0]; end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) r = a; else if (ovf) r = '0; else begin p = sa % sb; r = p[31:0]; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic fast_elig(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef GECKO_MULDIV_FASTPATH_EN
        if (op < 3'd4) return (a == 0) || (b == 0);
        if (b == 0) return 1'b1;
        return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`else
        return (op == 3'd7) && (op != 3'd7) && (a == b);
`endif
    endfunction

    // One full transaction; flush_at>0 pulses flush (non-speculative op must survive it).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold,
                          input int flush_at);
        int n, lat0, lat4, exp0, exp4;
        logic [4:0] addr;
        addr = 5'($urandom_range(1, 31));
        exp0 = fast_elig(op, a, b) ? 1 : 33;
        exp4 = fast_elig(op, a, b) ? 1 : 9;
        @(negedge clk);
        check({tag, "_cmd_ready_idle"}, {crdy0, crdy4}, 2'b11);
        cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = a; cmd_rs2 = b;
        cmd_reg_addr = addr; cmd_speculative = 1'b0;
        n = 0; lat0 = 0; lat4 = 0;
        while ((lat0 == 0 || lat4 == 0) && n < 80) begin
            @(negedge clk);
            n++;
            cmd_valid = 1'b0;
            if (n == 1) check({tag, "_busy_ready"}, {busy0, busy4, crdy0, crdy4}, 4'b1100);
            if (rv0 && lat0 == 0) lat0 = n;
            if (rv4 && lat4 == 0) lat4 = n;
            if (flush_at > 0 && n == flush_at) flush = 1'b1;
            if (flush_at > 0 && n == flush_at + 2) flush = 1'b0;
        end
        flush = 1'b0;
        check({tag, "_lat_bpc1"}, lat0, exp0);
        check({tag, "_lat_bpc4"}, lat4, exp4);
        check({tag, "_val_bpc1"}, val0, exp);
        check({tag, "_val_bpc4"}, val4, exp);
        check({tag, "_addr"}, {ad0, ad4}, {addr, addr});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {rv0, rv4, crdy0, val0, val4}, {3'b110, exp, exp});
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_release"}, {rv0, rv4, crdy0, crdy4}, 4'b0011);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] specials [6];
        specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h2;

        #12;
        check("reset_outputs", {crdy0, crdy4, rv0, rv4, busy0, busy4, val0, val4, ad0, ad4}, '0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5, 0);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 0);
        run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0);
        run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_op("div_neg_by0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_op("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 0, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 0, 0);

        // Speculative divide killed by flush while in flight.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rs1 = 32'hFFFF_FFF9; cmd_rs2 = 32'd2;
        cmd_speculative = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cmd_speculative = 1'b0;
        check("flush_spec", {rv0, rv4, busy0, busy4}, 4'b0000);
        run_op("after_flush", 3'd0, 32'd6, 32'd9, 32'd54, 0, 0);
        run_op("nonspec_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 0, 10);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs1 = 32'd11; cmd_rs2 = 32'd13;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("mid_reset", {rv0, rv4, busy0, busy4, crdy0, crdy4}, '0);
        @(negedge clk);
        check("in_reset_ready", {crdy0, crdy4}, 2'b00);
        rst = 1'b1;
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 0, 0);

        for (int k = 0; k < 30; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            run_op("random", rop, ra, rb, model(rop, ra, rb), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
